// File: rtl/host_cmd_parser.sv
// Host command parser: frames request packets popped from the bridge RX FIFO, runs one register access, pushes a 4-byte response.
// Latency: 2 cycles per received byte; register strobe at CHK capture +1, first response push at +3.
// Backpressure: pops only while RX is not empty; pushes only while TX is not full, and the byte index holds while full.
module host_cmd_parser #(
    parameter int unsigned pTimeout  = 50000,
    parameter logic [7:0]  pSync     = 8'hA5,
    parameter logic [7:0]  pRespSync = 8'h5A
) (
    input  logic       iClk,
    input  logic       iRst,
    output logic       oRxEn,
    input  logic       iRxEmpty,
    input  logic [7:0] iRxData,
    output logic       oTxEn,
    output logic [7:0] oTxData,
    input  logic       iTxFull,
    output logic [7:0] oRegAddr,
    output logic [7:0] oRegWrData,
    output logic       oRegWr,
    output logic       oRegRd,
    input  logic [7:0] iRegRdData,
    output logic       oBusy,
    output logic [7:0] oErrCount
);

    localparam int TW = $clog2(pTimeout + 1);

    localparam logic [2:0] ST_SYNC = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;
    localparam logic [2:0] ST_EXEC = 3'd5;
    localparam logic [2:0] ST_WAIT = 3'd6;
    localparam logic [2:0] ST_RESP = 3'd7;

    localparam logic [7:0] CMD_RD      = 8'h01;
    localparam logic [7:0] CMD_WR      = 8'h02;
    localparam logic [7:0] STAT_OK     = 8'h00;
    localparam logic [7:0] STAT_BADCHK = 8'h01;
    localparam logic [7:0] STAT_BADCMD = 8'h02;

    logic [2:0]    state_q, state_d;
    logic          rx_en_q, rx_en_d;
    logic          cap_q;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    status_q, status_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [2:0]    idx_q, idx_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          reg_wr_q, reg_wr_d;
    logic          reg_rd_q, reg_rd_d;
    logic [7:0]    err_q;
    logic          err_inc;

    logic          rx_state;
    logic          hdr_state;
    logic          capture;
    logic          timeout;
    logic [7:0]    chk_calc;
    logic          chk_ok;
    logic          cmd_ok;
    logic [7:0]    chk_status;
    logic [7:0]    resp_byte;

    // A capture is the cycle after a pop; the header states are the ones guarded by the idle timeout.
    assign rx_state   = (state_q <= ST_CHK);
    assign hdr_state  = (state_q >= ST_CMD) && (state_q <= ST_CHK);
    assign capture    = rx_state && cap_q;
    assign timeout    = hdr_state && !capture && (to_q == TW'(pTimeout - 1));

    // Checksum wins over command validity when both are wrong.
    assign chk_calc   = cmd_q ^ addr_q ^ ((cmd_q == CMD_WR) ? wdata_q : 8'h00);
    assign chk_ok     = (chk_calc == iRxData);
    assign cmd_ok     = (cmd_q == CMD_RD) || (cmd_q == CMD_WR);
    assign chk_status = !chk_ok ? STAT_BADCHK : (!cmd_ok ? STAT_BADCMD : STAT_OK);

    // Response byte selected by the push index.
    always_comb begin
        resp_byte = status_q ^ rdata_q;
        case (idx_q)
            3'd0:    resp_byte = pRespSync;
            3'd1:    resp_byte = status_q;
            3'd2:    resp_byte = rdata_q;
            default: resp_byte = status_q ^ rdata_q;
        endcase
    end

    // Packet FSM: byte framing, execute strobes, response sequencing and timeout abort.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        status_d  = status_q;
        rdata_d   = rdata_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        reg_wr_d  = 1'b0;
        reg_rd_d  = 1'b0;
        err_inc   = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (capture && (iRxData == pSync)) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (capture) begin
                    cmd_d   = iRxData;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (capture) begin
                    addr_d  = iRxData;
                    state_d = (cmd_q == CMD_WR) ? ST_DATA : ST_CHK;
                end
            end
            ST_DATA: begin
                if (capture) begin
                    wdata_d = iRxData;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (capture) begin
                    status_d = chk_status;
                    err_inc  = (chk_status != STAT_OK);
                    reg_wr_d = (chk_status == STAT_OK) && (cmd_q == CMD_WR);
                    reg_rd_d = (chk_status == STAT_OK) && (cmd_q == CMD_RD);
                    rdata_d  = ((chk_status == STAT_OK) && (cmd_q == CMD_WR)) ? wdata_q : 8'h00;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is valid exactly one cycle after the read strobe.
                if ((status_q == STAT_OK) && (cmd_q == CMD_RD)) rdata_d = iRegRdData;
                state_d = ST_RESP;
                if (!iTxFull) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = pRespSync;
                    idx_d     = 3'd1;
                end else begin
                    idx_d     = 3'd0;
                end
            end
            default: begin
                // idx_q == 4 means the last push is on the bus this cycle.
                if (idx_q == 3'd4) begin
                    state_d = ST_SYNC;
                end else if (!iTxFull) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = resp_byte;
                    idx_d     = idx_q + 3'd1;
                end
            end
        endcase
        if (timeout) begin
            state_d = ST_SYNC;
            err_inc = 1'b1;
        end
    end

    // Idle counter reloads on every capture and only runs inside the header states.
    always_comb begin
        to_d = '0;
        if (hdr_state && !capture && !timeout) to_d = to_q + TW'(1);
    end

    // Issue a pop only when none is outstanding and the next state still wants bytes.
    always_comb begin
        rx_en_d = !rx_en_q && (state_d <= ST_CHK) && !iRxEmpty;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_SYNC;
            rx_en_q   <= 1'b0;
            cap_q     <= 1'b0;
            to_q      <= '0;
            cmd_q     <= 8'h00;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            status_q  <= 8'h00;
            rdata_q   <= 8'h00;
            idx_q     <= 3'd0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            reg_wr_q  <= 1'b0;
            reg_rd_q  <= 1'b0;
            err_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            rx_en_q   <= rx_en_d;
            cap_q     <= rx_en_q;
            to_q      <= to_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
            idx_q     <= idx_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            reg_wr_q  <= reg_wr_d;
            reg_rd_q  <= reg_rd_d;
            if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
        end
    end

    assign oRxEn      = rx_en_q;
    assign oTxEn      = tx_en_q;
    assign oTxData    = tx_data_q;
    assign oRegAddr   = addr_q;
    assign oRegWrData = wdata_q;
    assign oRegWr     = reg_wr_q;
    assign oRegRd     = reg_rd_q;
    assign oBusy      = (state_q != ST_SYNC);
    assign oErrCount  = err_q;

endmodule

// File: tb/tb_host_cmd_parser.sv
// Bench for host_cmd_parser: packet-level reference model plus a per-cycle monitor acting as bridge and register slave.
// Latency of strobes and first response byte is checked against the last pop of each packet.
// TX backpressure is applied from the stimulus; RX bytes are served from a queue.
module tb_host_cmd_parser;

    localparam int TO = 16;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } op_t;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       oRxEn;
    logic       iRxEmpty = 1'b1;
    logic [7:0] iRxData = 8'h00;
    logic       oTxEn;
    logic [7:0] oTxData;
    logic       iTxFull = 1'b0;
    logic [7:0] oRegAddr;
    logic [7:0] oRegWrData;
    logic       oRegWr;
    logic       oRegRd;
    logic [7:0] iRegRdData = 8'h00;
    logic       oBusy;
    logic [7:0] oErrCount;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_pop = 0;
    int         fall_cyc = 0;
    int         tx_lat = 0;
    int         tx_in_resp = 0;
    int         nwr = 0;
    int         nrd = 0;
    logic       rd_prev = 1'b0;
    logic       busy_prev = 1'b0;
    logic [7:0] rd_val = 8'h00;
    logic [7:0] m_err = 8'h00;

    logic [7:0] rxq[$];
    logic [7:0] pkt[$];
    logic [7:0] exp_tx[$];
    logic [7:0] txlog[$];
    op_t        exp_ops[$];
    int         pops[$];

    host_cmd_parser #(.pTimeout(TO), .pSync(8'hA5), .pRespSync(8'h5A)) dut (
        .iClk(iClk), .iRst(iRst),
        .oRxEn(oRxEn), .iRxEmpty(iRxEmpty), .iRxData(iRxData),
        .oTxEn(oTxEn), .oTxData(oTxData), .iTxFull(iTxFull),
        .oRegAddr(oRegAddr), .oRegWrData(oRegWrData),
        .oRegWr(oRegWr), .oRegRd(oRegRd), .iRegRdData(iRegRdData),
        .oBusy(oBusy), .oErrCount(oErrCount)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic bump_err();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    // Reference model: one packet per call, derived from the request/response rules.
    task automatic send();
        int         i;
        int         need;
        logic [7:0] cmd;
        logic [7:0] adr;
        logic [7:0] dat;
        logic [7:0] st;
        logic [7:0] rd;
        op_t        op;
        foreach (pkt[j]) rxq.push_back(pkt[j]);
        i = 0;
        while (i < pkt.size() && pkt[i] != 8'hA5) i++;
        if (i >= pkt.size()) return;
        i++;
        if (i >= pkt.size()) begin bump_err(); return; end
        cmd  = pkt[i];
        need = (cmd == 8'h02) ? 4 : 3;
        if (pkt.size() - i < need) begin bump_err(); return; end
        adr = pkt[i+1];
        dat = (cmd == 8'h02) ? pkt[i+2] : 8'h00;
        if (pkt[i+need-1] != (cmd ^ adr ^ dat)) begin
            st = 8'h01; rd = 8'h00;
        end else if (cmd != 8'h01 && cmd != 8'h02) begin
            st = 8'h02; rd = 8'h00;
        end else begin
            st = 8'h00;
            rd = (cmd == 8'h02) ? dat : rd_val;
            op.wr = (cmd == 8'h02); op.addr = adr; op.data = dat;
            exp_ops.push_back(op);
        end
        if (st != 8'h00) bump_err();
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(st);
        exp_tx.push_back(rd);
        exp_tx.push_back(st ^ rd);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge iClk);
            n++;
        end while ((rxq.size() != 0 || exp_tx.size() != 0 || oBusy) && n < bound);
        repeat (3) @(negedge iClk);
        chk({name, "_done"}, n < bound, 1);
        chk({name, "_errcnt"}, oErrCount, m_err);
        chk({name, "_ops_left"}, exp_ops.size(), 0);
    endtask

    task automatic check_tx(input string name, input logic [31:0] req);
        logic [31:0] act;
        act = 32'h0;
        chk({name, "_n"}, txlog.size(), 4);
        foreach (txlog[i]) if (i < 4) act = {act[23:0], txlog[i]};
        chk(name, act, req);
        txlog.delete();
    endtask

    // Bridge / register-slave model and per-cycle comparison, sampled 1 time unit after each edge.
    always @(posedge iClk) begin
        op_t        op;
        logic [7:0] e;
        #1;
        cyc++;
        if (oRxEn) begin
            chk("rx_pop_nonempty", rxq.size() != 0, 1);
            if (rxq.size() != 0) iRxData = rxq.pop_front();
            last_pop = cyc;
            pops.push_back(cyc);
        end
        iRxEmpty   = (rxq.size() == 0);
        iRegRdData = rd_prev ? rd_val : 8'h00;
        rd_prev    = oRegRd;
        if (oRxEn || oTxEn) chk("rx_tx_exclusive", oRxEn & oTxEn, 0);
        if (oTxEn) begin
            chk("tx_not_full", iTxFull, 0);
            chk("tx_expected", exp_tx.size() != 0, 1);
            if (exp_tx.size() != 0) begin
                e = exp_tx.pop_front();
                chk("tx_byte", oTxData, e);
            end
            txlog.push_back(oTxData);
            if (tx_in_resp == 0) tx_lat = cyc - last_pop;
            tx_in_resp = (tx_in_resp + 1) % 4;
        end
        if (oRegWr || oRegRd) begin
            if (oRegWr) nwr++;
            if (oRegRd) nrd++;
            chk("op_expected", exp_ops.size() != 0, 1);
            if (exp_ops.size() != 0) begin
                op = exp_ops.pop_front();
                chk("op_kind", {oRegWr, oRegRd}, op.wr ? 2 : 1);
                chk("op_addr", oRegAddr, op.addr);
                if (op.wr) chk("op_wdata", oRegWrData, op.data);
                chk("op_latency", cyc - last_pop, 2);
            end
        end
        if (iRst) tx_in_resp = 0;
        if (busy_prev && !oBusy) fall_cyc = cyc;
        busy_prev = oBusy;
    end

    initial begin
        #800000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge iClk);
        chk("rst_strobes", {oRxEn, oTxEn, oRegWr, oRegRd, oBusy}, 0);
        chk("rst_data", {oTxData, oRegAddr, oRegWrData, oErrCount}, 0);
        iRst = 1'b0;
        @(negedge iClk);

        // Write
        pops.delete();
        pkt = '{8'hA5, 8'h02, 8'h10, 8'h3C, 8'h2E};
        send();
        wait_idle("wr", 500);
        check_tx("wr_tx", 32'h5A003C3C);
        chk("wr_pop_span", pops[4] - pops[0], 8);
        chk("wr_tx_lat", tx_lat, 4);
        chk("wr_strobes", nwr, 1);
        chk("wr_err_lit", oErrCount, 0);

        // Read
        rd_val = 8'hC7;
        pkt = '{8'hA5, 8'h01, 8'h20, 8'h21};
        send();
        wait_idle("rd", 500);
        check_tx("rd_tx", 32'h5A00C7C7);
        chk("rd_tx_lat", tx_lat, 4);
        chk("rd_strobes", nrd, 1);

        // Bad checksum, then bad command
        pkt = '{8'hA5, 8'h02, 8'h10, 8'h3C, 8'h00};
        send();
        wait_idle("badchk", 500);
        check_tx("badchk_tx", 32'h5A010001);
        chk("badchk_err_lit", oErrCount, 1);
        chk("badchk_no_wr", nwr, 1);
        pkt = '{8'hA5, 8'h07, 8'h00, 8'h07};
        send();
        wait_idle("badcmd", 500);
        check_tx("badcmd_tx", 32'h5A020002);
        chk("badcmd_err_lit", oErrCount, 2);
        chk("badcmd_no_rd", nrd, 1);

        // Leading garbage ignored
        rd_val = 8'h3B;
        pkt = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h20, 8'h21};
        send();
        wait_idle("resync", 500);
        check_tx("resync_tx", 32'h5A003B3B);
        chk("resync_err_lit", oErrCount, 2);

        // Starved packet times out
        pkt = '{8'hA5, 8'h01};
        send();
        wait_idle("timeout", 500);
        chk("timeout_no_tx", txlog.size(), 0);
        chk("timeout_err_lit", oErrCount, 3);
        chk("timeout_lat", fall_cyc - last_pop, TO + 2);

        // TX backpressure for 10 cycles after the first push
        pkt = '{8'hA5, 8'h02, 8'h44, 8'h99, 8'hDF};
        send();
        n = 0;
        while (txlog.size() < 1 && n < 200) begin @(negedge iClk); n++; end
        iTxFull = 1'b1;
        repeat (10) @(negedge iClk);
        chk("bp_hold", txlog.size(), 1);
        iTxFull = 1'b0;
        wait_idle("bp", 500);
        check_tx("bp_tx", 32'h5A009999);

        // Reset after the second response byte
        rd_val = 8'hC7;
        pkt = '{8'hA5, 8'h01, 8'h20, 8'h21};
        send();
        n = 0;
        while (txlog.size() < 2 && n < 200) begin @(negedge iClk); n++; end
        iRst = 1'b1;
        rxq.delete();
        exp_tx.delete();
        exp_ops.delete();
        m_err = 8'h00;
        @(negedge iClk);
        chk("midrst_strobes", {oRxEn, oTxEn, oRegWr, oRegRd, oBusy}, 0);
        chk("midrst_data", {oTxData, oRegAddr, oRegWrData, oErrCount}, 0);
        iRst = 1'b0;
        repeat (10) @(negedge iClk);
        chk("midrst_no_tx", txlog.size(), 2);
        txlog.delete();

        // Normal traffic after reset
        pkt = '{8'hA5, 8'h02, 8'h7F, 8'h01, 8'h7C};
        send();
        wait_idle("postrst", 500);
        check_tx("postrst_tx", 32'h5A000101);

        // Error counter saturation with back-to-back packets
        for (int k = 0; k < 256; k++) begin
            pkt = '{8'hA5, 8'h07, 8'h00, 8'h07};
            send();
        end
        wait_idle("sat", 8000);
        chk("sat_err_lit", oErrCount, 8'hFF);
        chk("sat_tx_n", txlog.size(), 1024);
        txlog.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
